jellyvl_synctimer_slew_timer: RTL and testbench

Free-running local timer for the synctimer subsystem. It advances by a fractional rate NUMERATOR/DENOMINATOR per clock. Time corrections of arbitrary signed size are slewed: spread over consecutive cycles, at most ADJ_STEP_MAX units per cycle, so `current_time` never jumps and never runs backwards. It sits between the synctimer control loop, which issues `set_*` and `adjust_*`, and every consumer of local time.

---
 rtl/jellyvl_synctimer_slew_timer_if.sv | 47 ++++
 rtl/jellyvl_synctimer_slew_timer.sv | 112 +++++++++++
 tb/tb_jellyvl_synctimer_slew_timer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/jellyvl_synctimer_slew_timer_if.sv
// jellyvl_synctimer_slew_timer_if
//
// Bundles the control-loop side of the slew timer into a single interface.
//
//   set_time / set_valid          absolute time load, always accepted
//   adjust_value / adjust_valid   signed correction request
//   adjust_ready                  correction accepted when high with adjust_valid
//   adjust_busy                   a slew is in progress
//   adjust_done                   one-cycle pulse when a slew completes
//   current_time                  local time
//
// The master modport is the synctimer control loop. The slave modport is the timer.
interface jellyvl_synctimer_slew_timer_if #(
    parameter int TIMER_WIDTH = 64,
    parameter int ADJ_WIDTH   = 32
);
    logic [TIMER_WIDTH-1:0] set_time;
    logic                   set_valid;
    logic [ADJ_WIDTH-1:0]   adjust_value;
    logic                   adjust_valid;
    logic                   adjust_ready;
    logic                   adjust_busy;
    logic                   adjust_done;
    logic [TIMER_WIDTH-1:0] current_time;

    modport master (
        output set_time,
        output set_valid,
        output adjust_value,
        output adjust_valid,
        input  adjust_ready,
        input  adjust_busy,
        input  adjust_done,
        input  current_time
    );

    modport slave (
        input  set_time,
        input  set_valid,
        input  adjust_value,
        input  adjust_valid,
        output adjust_ready,
        output adjust_busy,
        output adjust_done,
        output current_time
    );
endinterface

// File: rtl/jellyvl_synctimer_slew_timer.sv
// jellyvl_synctimer_slew_timer
//
// Free-running local timer. It advances by NUMERATOR/DENOMINATOR time units
// per clock. Signed corrections are slewed in at no more than ADJ_STEP_MAX
// units per cycle, so current_time never jumps and never runs backwards.
//
// Ports:
//   reset  asynchronous active-high reset
//   clk    clock
//   bus    slave side of jellyvl_synctimer_slew_timer_if (set, adjust, status, time)
module jellyvl_synctimer_slew_timer #(
    parameter int NUMERATOR    = 10,
    parameter int DENOMINATOR  = 3,
    parameter int TIMER_WIDTH  = 64,
    parameter int ADJ_WIDTH    = 32,
    parameter int ADJ_STEP_MAX = 1
) (
    input  logic                           reset,
    input  logic                           clk,
    jellyvl_synctimer_slew_timer_if.slave  bus
);

    localparam int COUNT_NUM = NUMERATOR / DENOMINATOR;
    localparam int COUNT_ERR = NUMERATOR % DENOMINATOR;
    localparam int THR       = DENOMINATOR - COUNT_ERR;
    localparam int ERR_WIDTH = (DENOMINATOR > 1) ? $clog2(DENOMINATOR) : 1;

    localparam logic [ERR_WIDTH-1:0] THR_E       = ERR_WIDTH'(THR);
    localparam logic [ERR_WIDTH-1:0] COUNT_ERR_E = ERR_WIDTH'(COUNT_ERR);

    localparam logic signed [ADJ_WIDTH:0] STEP_POS = (ADJ_WIDTH+1)'(ADJ_STEP_MAX);
    localparam logic signed [ADJ_WIDTH:0] STEP_NEG = -STEP_POS;

    logic [ERR_WIDTH-1:0]          err_q, err_d;
    logic signed [ADJ_WIDTH:0]     pending_q, pending_d;
    logic [TIMER_WIDTH-1:0]        time_q, time_d;
    logic                          done_q, done_d;

    logic                          carry;
    logic [TIMER_WIDTH-1:0]        base_inc;
    logic signed [ADJ_WIDTH:0]     delta;
    logic [TIMER_WIDTH-1:0]        delta_ext;
    logic signed [ADJ_WIDTH:0]     adjust_ext;
    logic                          accept;

    // Ready only when no slew is outstanding and no load is competing this cycle.
    assign bus.adjust_ready = (pending_q == '0) && !bus.set_valid;
    assign bus.adjust_busy  = (pending_q != '0);
    assign bus.adjust_done  = done_q;
    assign bus.current_time = time_q;

    assign accept     = bus.adjust_valid && bus.adjust_ready;
    // pending is one bit wider than adjust_value, so the most negative value
    // still has a representable magnitude.
    assign adjust_ext = {bus.adjust_value[ADJ_WIDTH-1], bus.adjust_value};

    // Fractional rate accumulator. err advances every cycle regardless of
    // set/adjust activity, so the long-term rate is exactly NUMERATOR/DENOMINATOR.
    always_comb begin
        carry = 1'b0;
        if (COUNT_ERR != 0) begin
            carry = (32'(err_q) >= THR);
        end
        err_d    = carry ? (err_q - THR_E) : (err_q + COUNT_ERR_E);
        base_inc = TIMER_WIDTH'(COUNT_NUM) + TIMER_WIDTH'(carry);
    end

    // Slew step: clamp the outstanding correction to +/-ADJ_STEP_MAX. Because
    // ADJ_STEP_MAX never exceeds COUNT_NUM, base_inc + delta is never negative.
    always_comb begin
        delta = pending_q;
        if (pending_q > STEP_POS) begin
            delta = STEP_POS;
        end else if (pending_q < STEP_NEG) begin
            delta = STEP_NEG;
        end
        delta_ext = TIMER_WIDTH'(delta);
    end

    // Next-state for time and pending. A load wins over everything and cancels
    // any slew. An accept only happens while pending is zero, so delta is zero
    // in that cycle and the new correction starts moving on the following edge.
    always_comb begin
        time_d    = time_q + base_inc + delta_ext;
        pending_d = pending_q - delta;
        if (bus.set_valid) begin
            time_d    = bus.set_time + base_inc;
            pending_d = '0;
        end else if (accept) begin
            pending_d = adjust_ext;
        end
        // done fires only when a real slew finishes on its own, not when a load cancels it.
        done_d = (pending_q != '0) && (pending_d == '0) && !bus.set_valid;
    end

    // State registers. Reset clears everything asynchronously, so a slew in
    // flight is dropped without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q     <= '0;
            pending_q <= '0;
            time_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            err_q     <= err_d;
            pending_q <= pending_d;
            time_q    <= time_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_jellyvl_synctimer_slew_timer.sv
// tb_jellyvl_synctimer_slew_timer
//
// Directed bench for the slew timer. dut_a runs at 10/3 with a 64-bit timer
// and a step of 2. dut_b runs at 10/3 with an 8-bit timer, an 8-bit adjust
// and a step of 3, for the wrap and most-negative cases.
module tb_jellyvl_synctimer_slew_timer;

    logic clk;
    logic reset_a;
    logic reset_b;

    int tests_run;
    int tests_failed;

    jellyvl_synctimer_slew_timer_if #(.TIMER_WIDTH(64), .ADJ_WIDTH(32)) bus_a ();
    jellyvl_synctimer_slew_timer_if #(.TIMER_WIDTH(8),  .ADJ_WIDTH(8))  bus_b ();

    jellyvl_synctimer_slew_timer #(
        .NUMERATOR(10), .DENOMINATOR(3), .TIMER_WIDTH(64), .ADJ_WIDTH(32), .ADJ_STEP_MAX(2)
    ) dut_a (
        .reset (reset_a),
        .clk   (clk),
        .bus   (bus_a)
    );

    jellyvl_synctimer_slew_timer #(
        .NUMERATOR(10), .DENOMINATOR(3), .TIMER_WIDTH(8), .ADJ_WIDTH(8), .ADJ_STEP_MAX(3)
    ) dut_b (
        .reset (reset_b),
        .clk   (clk),
        .bus   (bus_b)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive the control-loop inputs of dut_a.
    task automatic applyStimulus(input logic set_v, input logic [63:0] set_t,
                                 input logic adj_v, input logic [31:0] adj_val);
        bus_a.set_valid    = set_v;
        bus_a.set_time     = set_t;
        bus_a.adjust_valid = adj_v;
        bus_a.adjust_value = adj_val;
    endtask

    // Advance one edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset dut_a and run 30 edges so it sits at time 100 with err = 0.
    task automatic resetFreeRun();
        reset_a = 1'b1;
        #2;
        reset_a = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        checkOutput("freerun_time", bus_a.current_time, 64'd100);
    endtask

    int inc_pattern [3] = '{3, 3, 4};
    logic [63:0] exp_time;
    int cnt;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_a      = 1'b1;
        reset_b      = 1'b1;
        applyStimulus(1'b0, 64'd0, 1'b0, 32'd0);
        bus_b.set_valid    = 1'b0;
        bus_b.set_time     = 8'd0;
        bus_b.adjust_valid = 1'b0;
        bus_b.adjust_value = 8'd0;

        // Reset state.
        tick();
        checkOutput("reset_time",  bus_a.current_time, 64'd0);
        checkOutput("reset_busy",  {63'd0, bus_a.adjust_busy}, 64'd0);
        checkOutput("reset_done",  {63'd0, bus_a.adjust_done}, 64'd0);
        checkOutput("reset_ready", {63'd0, bus_a.adjust_ready}, 64'd1);

        // Free run: increments 3,3,4 repeating, 100 after 30 edges.
        reset_a  = 1'b0;
        exp_time = 64'd0;
        for (int i = 0; i < 30; i++) begin
            tick();
            exp_time = exp_time + 64'(inc_pattern[i % 3]);
            if (i < 6) checkOutput("freerun_step", bus_a.current_time, exp_time);
        end
        checkOutput("freerun_100",   bus_a.current_time, 64'd100);
        checkOutput("freerun_ready", {63'd0, bus_a.adjust_ready}, 64'd1);
        checkOutput("freerun_busy",  {63'd0, bus_a.adjust_busy}, 64'd0);

        // Positive slew +5: 103, 108, 114, 118.
        applyStimulus(1'b0, 64'd0, 1'b1, 32'd5);
        checkOutput("pos_ready", {63'd0, bus_a.adjust_ready}, 64'd1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b0, 32'd0);
        checkOutput("pos_t1", bus_a.current_time, 64'd103);
        checkOutput("pos_busy1", {63'd0, bus_a.adjust_busy}, 64'd1);
        tick();
        checkOutput("pos_t2", bus_a.current_time, 64'd108);
        checkOutput("pos_busy2", {63'd0, bus_a.adjust_busy}, 64'd1);
        tick();
        checkOutput("pos_t3", bus_a.current_time, 64'd114);
        checkOutput("pos_busy3", {63'd0, bus_a.adjust_busy}, 64'd1);
        checkOutput("pos_nodone3", {63'd0, bus_a.adjust_done}, 64'd0);
        tick();
        checkOutput("pos_t4", bus_a.current_time, 64'd118);
        checkOutput("pos_busy4", {63'd0, bus_a.adjust_busy}, 64'd0);
        checkOutput("pos_done", {63'd0, bus_a.adjust_done}, 64'd1);
        tick();
        checkOutput("pos_t5", bus_a.current_time, 64'd121);
        checkOutput("pos_done_once", {63'd0, bus_a.adjust_done}, 64'd0);

        // Negative slew -5 with a second request held during the slew.
        resetFreeRun();
        applyStimulus(1'b0, 64'd0, 1'b1, 32'hFFFF_FFFB);
        tick();
        checkOutput("neg_t1", bus_a.current_time, 64'd103);
        applyStimulus(1'b0, 64'd0, 1'b1, 32'd2);
        checkOutput("neg_ready1", {63'd0, bus_a.adjust_ready}, 64'd0);
        tick();
        checkOutput("neg_t2", bus_a.current_time, 64'd104);
        checkOutput("neg_ready2", {63'd0, bus_a.adjust_ready}, 64'd0);
        tick();
        checkOutput("neg_t3", bus_a.current_time, 64'd106);
        checkOutput("neg_ready3", {63'd0, bus_a.adjust_ready}, 64'd0);
        tick();
        checkOutput("neg_t4", bus_a.current_time, 64'd108);
        checkOutput("neg_done", {63'd0, bus_a.adjust_done}, 64'd1);
        checkOutput("neg_ready4", {63'd0, bus_a.adjust_ready}, 64'd1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b0, 32'd0);
        checkOutput("held_t5", bus_a.current_time, 64'd111);
        checkOutput("held_busy", {63'd0, bus_a.adjust_busy}, 64'd1);
        tick();
        checkOutput("held_t6", bus_a.current_time, 64'd117);
        checkOutput("held_done", {63'd0, bus_a.adjust_done}, 64'd1);

        // Set and adjust together during a slew: set wins, slew cancelled.
        applyStimulus(1'b0, 64'd0, 1'b1, 32'd100);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b0, 32'd0);
        checkOutput("sv_t1", bus_a.current_time, 64'd120);
        tick();
        checkOutput("sv_t2", bus_a.current_time, 64'd125);
        applyStimulus(1'b1, 64'd1000, 1'b1, 32'd7);
        checkOutput("sv_ready", {63'd0, bus_a.adjust_ready}, 64'd0);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b0, 32'd0);
        checkOutput("sv_time", bus_a.current_time, 64'd1004);
        checkOutput("sv_busy", {63'd0, bus_a.adjust_busy}, 64'd0);
        checkOutput("sv_nodone", {63'd0, bus_a.adjust_done}, 64'd0);
        tick();
        checkOutput("sv_after", bus_a.current_time, 64'd1007);
        checkOutput("sv_after_busy", {63'd0, bus_a.adjust_busy}, 64'd0);
        checkOutput("sv_after_done", {63'd0, bus_a.adjust_done}, 64'd0);

        // Reset asserted between edges during a +100 slew.
        applyStimulus(1'b0, 64'd0, 1'b1, 32'd100);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b0, 32'd0);
        checkOutput("rst_t1", bus_a.current_time, 64'd1010);
        tick();
        checkOutput("rst_t2", bus_a.current_time, 64'd1016);
        checkOutput("rst_busy_pre", {63'd0, bus_a.adjust_busy}, 64'd1);
        #2;
        reset_a = 1'b1;
        #1;
        checkOutput("rst_async_time", bus_a.current_time, 64'd0);
        checkOutput("rst_async_busy", {63'd0, bus_a.adjust_busy}, 64'd0);
        checkOutput("rst_async_done", {63'd0, bus_a.adjust_done}, 64'd0);
        #1;
        reset_a = 1'b0;
        tick();
        checkOutput("rst_run1", bus_a.current_time, 64'd3);
        tick();
        checkOutput("rst_run2", bus_a.current_time, 64'd6);
        tick();
        checkOutput("rst_run3", bus_a.current_time, 64'd10);
        checkOutput("rst_run_done", {63'd0, bus_a.adjust_done}, 64'd0);

        // 8-bit wrap: load 254 on the first edge (base_inc 3) gives 1.
        reset_b = 1'b0;
        bus_b.set_valid = 1'b1;
        bus_b.set_time  = 8'd254;
        tick();
        bus_b.set_valid = 1'b0;
        checkOutput("wrap_t1", {56'd0, bus_b.current_time}, 64'd1);
        tick();
        checkOutput("wrap_t2", {56'd0, bus_b.current_time}, 64'd4);
        tick();
        checkOutput("wrap_t3", {56'd0, bus_b.current_time}, 64'd8);

        // Most negative adjust (-128, step 3): 43 delta cycles, ends at 26.
        bus_b.adjust_valid = 1'b1;
        bus_b.adjust_value = 8'h80;
        tick();
        bus_b.adjust_valid = 1'b0;
        bus_b.adjust_value = 8'h00;
        checkOutput("maxneg_t1", {56'd0, bus_b.current_time}, 64'd11);
        checkOutput("maxneg_busy", {63'd0, bus_b.adjust_busy}, 64'd1);
        cnt = 0;
        while (cnt < 60 && !bus_b.adjust_done) begin
            tick();
            cnt++;
        end
        checkOutput("maxneg_cycles", 64'(cnt), 64'd43);
        checkOutput("maxneg_time", {56'd0, bus_b.current_time}, 64'd26);
        checkOutput("maxneg_idle", {63'd0, bus_b.adjust_busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
